// File: rtl/serial_sub8.sv
// Bit-serial subtractor: d = a + ~b + 1 through one full-adder cell and a carry flop, LSB first.
// Start/done handshake; the result and flags hold until the next operation completes.
module serial_sub8 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_a_q;
  logic               sign_b_q;

  logic               sum_bit;
  logic               carry_d;
  logic [WIDTH-1:0]   res_d;
  logic               last_bit;

  always_comb begin
    sum_bit  = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    carry_d  = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
    res_d    = {sum_bit, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      d_o      <= '0;
      bout_o   <= 1'b0;
      ovf_o    <= 1'b0;
      zero_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            // Invert b here and seed carry with 1 so the adder cell performs a - b.
            op_a_q   <= a_i;
            op_b_q   <= ~b_i;
            carry_q  <= 1'b1;
            cnt_q    <= '0;
            sign_a_q <= a_i[WIDTH-1];
            sign_b_q <= b_i[WIDTH-1];
            busy_o   <= 1'b1;
            state_q  <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          op_a_q  <= op_a_q >> 1;
          op_b_q  <= op_b_q >> 1;
          res_q   <= res_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            d_o     <= res_d;
            bout_o  <= ~carry_d;
            ovf_o   <= (sign_a_q != sign_b_q) && (res_d[WIDTH-1] != sign_a_q);
            zero_o  <= (res_d == '0);
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
